button_pulse_gen: RTL and testbench
===================================

// Module: button_pulse_gen
// PURPOSE
//  Upstream stage of the PWM duty controller. Conditions two raw, asynchronous push-button inputs
//  (increment, decrement) into clean single-cycle pulses: synchronise, debounce, detect press edges.
//  Held buttons auto-repeat. Outputs drive the duty_inc/duty_dec inputs of the PWM generator directly.
// PARAMETERS
//  SYNC_STAGES     2     flops in each input synchroniser (>=2)
//  DEBOUNCE_CYCLES 16    consecutive identical synced samples required to accept a level change
//  REPEAT_DELAY    256   cycles from accepted press to first auto-repeat pulse
//  REPEAT_PERIOD   64    cycles between subsequent auto-repeat pulses
//  CNT_W           16    width of debounce/repeat counters; all cycle params must be < 2**CNT_W
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  btn_inc_raw in   1  raw increment button, active-high, asynchronous to clk
//  btn_dec_raw in   1  raw decrement button, active-high, asynchronous to clk
//  duty_inc    out  1  one-cycle increment request to PWM stage
//  duty_dec    out  1  one-cycle decrement request to PWM stage
//  conflict    out  1  one-cycle flag: both requests fell in same cycle and were dropped
// BEHAVIOUR
//  - Reset: every output 0, all synchroniser flops 0, counters 0, both channel FSMs in IDLE.
//    Reset asserted mid-operation aborts any press/repeat at once; no pulse is emitted on release of rst.
//  - Each button has an independent channel: SYNC_STAGES-flop synchroniser, then FSM + one CNT_W counter.
//  - FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
//    IDLE: synced=1 -> PRESS_DB, cnt<=1.
//    PRESS_DB: synced=0 -> IDLE, cnt<=0 (bounce rejected). synced=1: cnt++;
//      when cnt reaches DEBOUNCE_CYCLES -> HELD, emit pulse that cycle, cnt<=0.
//    HELD: synced=1: cnt++; at cnt=REPEAT_DELAY-1 emit pulse; thereafter every REPEAT_PERIOD cycles.
//      Repeat counter saturates into a free period counter; it never wraps silently.
//      synced=0 -> RELEASE_DB, cnt<=1.
//    RELEASE_DB: synced=1 -> HELD (glitch; repeat timing continues from the saved phase, no extra pulse).
//      synced=0 for DEBOUNCE_CYCLES cycles -> IDLE. No pulses are emitted in RELEASE_DB.
//  - Latency: a clean press stable from cycle 0 yields the first pulse registered at
//    cycle SYNC_STAGES+DEBOUNCE_CYCLES (+/-1 for metastability resolution). Outputs are registered.
//  - Pulse width is exactly 1 cycle. Pulses on one output are spaced >= REPEAT_PERIOD cycles apart.
//  - Arbitration: if both channels want to pulse in the same cycle, duty_inc=duty_dec=0 and conflict=1.
//    duty_inc and duty_dec are never both 1.
//  - A button held through reset deassertion counts as a new press (IDLE->PRESS_DB), one pulse.
// STRUCTURE
//  - Shared package pwm_ctrl_pkg: FSM state encoding (2-bit localparams IDLE/PRESS_DB/HELD/RELEASE_DB),
//    default timing constants shared with the PWM generator's step size.
//  - Sub-module btn_channel (sync + debounce + repeat FSM, one button), instantiated twice;
//    top level holds only the arbitration and output registers.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, SYNC_STAGES=2)
//  1. rst high 5 cycles, inputs toggling -> all outputs 0 throughout; 0 after release with inputs low.
//  2. btn_inc_raw 0->1 held 10 cycles then 0 -> exactly one duty_inc pulse, 6 cycles after rise (+/-1).
//  3. btn_dec_raw bounces 1,0,1,0 at 1-cycle spacing then stable 1 -> no pulse during bounce,
//     one duty_dec pulse 6 cycles after final rise.
//  4. btn_inc_raw held 60 cycles -> pulses at ~6, ~26, ~34, ~42, ~50, ~58 cycles after rise.
//  5. Both buttons rise on the same cycle -> conflict=1 for 1 cycle, duty_inc=duty_dec=0 that cycle.
//  6. rst asserted 2 cycles mid-HELD -> outputs 0 immediately; if button still held,
//     one new pulse 6 cycles after rst falls.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty controller front end.
//  - Button channel FSM state encoding (2-bit, legacy-compatible constants).
//  - Default timing constants, also used by the PWM generator for its step size.
//  - Request bundle passed from arbitration to the output registers.
package pwm_ctrl_pkg;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 256;
  localparam int DEF_REPEAT_PERIOD   = 64;
  localparam int DEF_CNT_W           = 16;

  // Duty change applied by the PWM generator per inc/dec request.
  localparam int DUTY_STEP = 1;

  typedef struct packed {
    logic inc;
    logic dec;
    logic conflict;
  } duty_req_t;

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: synchroniser, debounce and auto-repeat FSM.
// Ports:
//  clk, rst  - clock, asynchronous active-high reset
//  btn_raw   - raw asynchronous button level, active-high
//  want      - combinational: channel wants to emit a pulse this cycle
//              (registered by the top after arbitration)
module btn_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic want
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [1:0]             state;
  logic [CNT_W-1:0]       db_cnt;     // press/release debounce count
  logic [CNT_W-1:0]       rpt_cnt;    // repeat phase, frozen while release is debounced
  logic                   rpt_phase;  // 0: waiting initial delay, 1: periodic repeat
  logic [CNT_W-1:0]       rpt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign rpt_last = rpt_phase ? RP_LAST : RD_LAST;

  always_comb begin
    want = 1'b0;
    case (state)
      PRESS_DB: want = synced && (db_cnt == DB_LAST);
      HELD:     want = synced && (rpt_cnt == rpt_last);
      default:  want = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (synced) begin
            state  <= PRESS_DB;
            db_cnt <= ONE;
          end
        end
        PRESS_DB: begin
          if (!synced) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state     <= HELD;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
          end else begin
            db_cnt <= db_cnt + ONE;
          end
        end
        HELD: begin
          if (!synced) begin
            state  <= RELEASE_DB;
            db_cnt <= ONE;
          end else if (rpt_cnt == rpt_last) begin
            // After the initial delay the counter becomes a period counter
            // and restarts from zero, so it can never wrap.
            rpt_cnt   <= '0;
            rpt_phase <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + ONE;
          end
        end
        RELEASE_DB: begin
          if (synced) begin
            // Glitch: resume repeat from the saved phase, no pulse.
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Conditions the increment/decrement push buttons into single-cycle
// duty change requests for the PWM generator.
// Ports:
//  clk, rst     - clock, asynchronous active-high reset
//  btn_inc_raw  - raw increment button (async, active-high)
//  btn_dec_raw  - raw decrement button (async, active-high)
//  duty_inc     - registered one-cycle increment request
//  duty_dec     - registered one-cycle decrement request
//  conflict     - registered one-cycle flag, both requests collided and were dropped
module button_pulse_gen
  import pwm_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic duty_inc,
  output logic duty_dec,
  output logic conflict
);

  logic      inc_want, dec_want;
  duty_req_t req_d, req_q;

  btn_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
  ) u_inc (
    .clk(clk), .rst(rst), .btn_raw(btn_inc_raw), .want(inc_want)
  );

  btn_channel #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
  ) u_dec (
    .clk(clk), .rst(rst), .btn_raw(btn_dec_raw), .want(dec_want)
  );

  // Simultaneous requests cancel; the PWM stage never sees both.
  always_comb begin
    req_d          = '0;
    req_d.inc      = inc_want & ~dec_want;
    req_d.dec      = dec_want & ~inc_want;
    req_d.conflict = inc_want &  dec_want;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_d;
  end

  assign duty_inc = req_q.inc;
  assign duty_dec = req_q.dec;
  assign conflict = req_q.conflict;

endmodule

// File: tb/tb_button_pulse_gen.sv
module tb_button_pulse_gen;
  localparam int SS = 2, DB = 4, RD = 20, RP = 8, CW = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic btn_inc_raw = 1'b0, btn_dec_raw = 1'b0;
  logic duty_inc, duty_dec, conflict;

  button_pulse_gen #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .btn_inc_raw(btn_inc_raw), .btn_dec_raw(btn_dec_raw),
    .duty_inc(duty_inc), .duty_dec(duty_dec), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  // Model: the synchronised level is the raw sample delayed SS cycles.
  // A press is accepted after DB consecutive high samples, released after DB
  // consecutive low ones. While pressed, held time counts high samples
  // (a low glitch and the sample that ends it do not count); pulses fire on
  // acceptance, at held time RD, and every RP after that.
  bit mh[2][SS];
  bit mdeb[2];
  int mrun1[2], mrun0[2], mheld[2];
  bit mwant[2];
  bit e_inc = 0, e_dec = 0, e_cf = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < SS; i++) mh[c][i] = 1'b0;
        mdeb[c] = 0; mrun1[c] = 0; mrun0[c] = 0; mheld[c] = 0; mwant[c] = 0;
      end
      e_inc = 0; e_dec = 0; e_cf = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit s, raw;
        raw = (c == 0) ? btn_inc_raw : btn_dec_raw;
        s = mh[c][SS-1];
        for (int i = SS-1; i > 0; i--) mh[c][i] = mh[c][i-1];
        mh[c][0] = raw;
        mwant[c] = 0;
        if (!mdeb[c]) begin
          mrun1[c] = s ? mrun1[c] + 1 : 0;
          if (mrun1[c] == DB) begin
            mdeb[c] = 1; mwant[c] = 1; mheld[c] = 0; mrun0[c] = 0;
          end
        end else if (s) begin
          if (mrun0[c] > 0) mrun0[c] = 0;
          else begin
            mheld[c]++;
            if (mheld[c] == RD || (mheld[c] > RD && (mheld[c] - RD) % RP == 0))
              mwant[c] = 1;
          end
        end else begin
          mrun0[c]++;
          if (mrun0[c] == DB) begin mdeb[c] = 0; mrun1[c] = 0; end
        end
      end
      e_inc = mwant[0] && !mwant[1];
      e_dec = mwant[1] && !mwant[0];
      e_cf  = mwant[0] && mwant[1];
    end
  end

  int inc_q[$], dec_q[$], cf_q[$];

  always @(negedge clk) begin
    chk("duty_inc", duty_inc, rst ? 1'b0 : e_inc);
    chk("duty_dec", duty_dec, rst ? 1'b0 : e_dec);
    chk("conflict", conflict, rst ? 1'b0 : e_cf);
    if (duty_inc === 1'b1) inc_q.push_back(cyc);
    if (duty_dec === 1'b1) dec_q.push_back(cyc);
    if (conflict === 1'b1) cf_q.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inc_q.delete(); dec_q.delete(); cf_q.delete();
  endtask

  int t0, t1;
  int exp4[6] = '{6, 26, 34, 42, 50, 58};
  int exp7[4] = '{6, 26, 37, 45};

  initial begin
    // 1: reset with toggling inputs
    tick(1);
    for (int i = 0; i < 5; i++) begin
      btn_inc_raw = i[0]; btn_dec_raw = ~i[0];
      tick(1);
    end
    btn_inc_raw = 0; btn_dec_raw = 0; rst = 0;
    tick(12);
    chk_int("t1_inc_count", inc_q.size() + dec_q.size() + cf_q.size(), 0);

    // 2: clean press, one pulse
    clr(); t0 = cyc; btn_inc_raw = 1; tick(10); btn_inc_raw = 0; tick(20);
    chk_int("t2_inc_count", inc_q.size(), 1);
    if (inc_q.size() > 0) chk_int("t2_inc_offset", inc_q[0] - t0, 6);

    // 3: bounce then stable
    clr();
    btn_dec_raw = 1; tick(1); btn_dec_raw = 0; tick(1);
    btn_dec_raw = 1; tick(1); btn_dec_raw = 0; tick(1);
    t0 = cyc; btn_dec_raw = 1; tick(12); btn_dec_raw = 0; tick(20);
    chk_int("t3_dec_count", dec_q.size(), 1);
    if (dec_q.size() > 0) chk_int("t3_dec_offset", dec_q[0] - t0, 6);

    // 4: auto-repeat
    clr(); t0 = cyc; btn_inc_raw = 1; tick(60); btn_inc_raw = 0; tick(20);
    chk_int("t4_inc_count", inc_q.size(), 6);
    for (int i = 0; i < 6 && i < inc_q.size(); i++)
      chk_int($sformatf("t4_inc_offset%0d", i), inc_q[i] - t0, exp4[i]);

    // 5: simultaneous press
    clr(); t0 = cyc; btn_inc_raw = 1; btn_dec_raw = 1; tick(10);
    btn_inc_raw = 0; btn_dec_raw = 0; tick(20);
    chk_int("t5_cf_count", cf_q.size(), 1);
    if (cf_q.size() > 0) chk_int("t5_cf_offset", cf_q[0] - t0, 6);
    chk_int("t5_reqs", inc_q.size() + dec_q.size(), 0);

    // 6: reset mid-HELD with button still down
    clr(); t0 = cyc; btn_inc_raw = 1; tick(30);
    rst = 1; tick(2); rst = 0; t1 = cyc; tick(12);
    btn_inc_raw = 0; tick(20);
    chk_int("t6_inc_count", inc_q.size(), 3);
    if (inc_q.size() == 3) chk_int("t6_after_rst", inc_q[2] - t1, 6);

    // 7: release glitch while held, repeat phase resumes
    clr(); t0 = cyc; btn_inc_raw = 1; tick(24);
    btn_inc_raw = 0; tick(2); btn_inc_raw = 1; tick(20);
    btn_inc_raw = 0; tick(20);
    chk_int("t7_inc_count", inc_q.size(), 4);
    for (int i = 0; i < 4 && i < inc_q.size(); i++)
      chk_int($sformatf("t7_inc_offset%0d", i), inc_q[i] - t0, exp7[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
